// File: rtl/dram_result_streamer_pkg.sv
// rtl/dram_result_streamer_pkg.sv - shared states, defaults and credit helper for the DRAM result streamer
package dram_result_streamer_pkg;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_PTR_ADDR     = 12;
    localparam int DEF_END_ADDR     = 511;
    localparam int DEF_BUSY_TIMEOUT = 64;
    localparam int CORE_CNT         = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_FETCH_PTR,
        ST_PTR_CAP,
        ST_STREAM,
        ST_DONE
    } state_t;

    // Skid-buffer slots committed at the next edge: what stays after this cycle's pop plus the
    // DRAM return landing this cycle. A new read may issue only while this is below 2.
    function automatic logic [2:0] credit_use(input logic [1:0] occ, input logic pop,
                                              input logic inflight);
        return 3'(occ) - 3'(pop) + 3'(inflight);
    endfunction

endpackage

// File: rtl/dram_result_streamer_skid_buf.sv
// rtl/dram_result_streamer_skid_buf.sv - 2-entry {last,data} buffer absorbing the DRAM read latency
module dram_result_streamer_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] buf_data [2];
    logic              buf_last [2];
    logic              rptr;
    logic              wptr;
    logic [1:0]        cnt;
    logic              push;
    logic              pop;

    assign m_tvalid = (cnt != 2'd0);
    assign m_tdata  = buf_data[rptr];
    assign m_tlast  = buf_last[rptr];
    assign s_tready = (cnt != 2'd2) | m_tready;
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;
    assign count    = cnt;

    // Circular two-slot store; the head never moves until popped, so output holds under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
            rptr        <= 1'b0;
            wptr        <= 1'b0;
            cnt         <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wptr] <= s_tdata;
                buf_last[wptr] <= s_tlast;
                wptr           <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/dram_result_streamer.sv
// rtl/dram_result_streamer.sv - drains DRAM[ptr..END_ADDR] to a valid/ready stream; STREAM_CHECKSUM_EN appends an XOR byte
module dram_result_streamer
    import dram_result_streamer_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int PTR_ADDR     = DEF_PTR_ADDR,
    parameter int END_ADDR     = DEF_END_ADDR,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [CORE_CNT-1:0] i_busy,
    output logic                o_dram_rd,
    output logic [ADDR_W-1:0]   o_dram_addr,
    input  logic [DATA_W-1:0]   i_dram_data,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_last,
    output logic                o_active,
    output logic                o_done
);

    localparam int              TO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PTR_A = ADDR_W'(PTR_ADDR);
    localparam logic [ADDR_W-1:0] END_A = ADDR_W'(END_ADDR);

    state_t              state;
    state_t              state_nxt;
    logic                start_q;
    logic [TO_W-1:0]     to_cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   base;
    logic                base_past_end;
    logic                rd_pending;
    logic                inflight;
    logic                inflight_last;
    logic                issue;
    logic                issue_last;
    logic                push_valid;
    logic                push_last;
    logic                push_ready;
    logic [DATA_W-1:0]   push_data;
    logic [1:0]          sb_count;
    logic                pop;

    assign base          = ADDR_W'(i_dram_data);
    assign base_past_end = (base > END_A);
    assign pop           = o_valid & i_ready;

`ifdef STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] ck;
    logic              ck_sent;
    logic              ck_push;

    // Checksum byte goes in only after every data return has been folded into ck.
    assign ck_push    = (state == ST_STREAM) & ~rd_pending & ~inflight & ~ck_sent & push_ready;
    assign push_valid = inflight | ck_push;
    assign push_data  = inflight ? i_dram_data : ck;
    assign push_last  = inflight ? inflight_last : 1'b1;
    assign issue_last = 1'b0;

    // XOR-fold each returned data byte; cleared when a new base pointer is captured.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ck      <= '0;
            ck_sent <= 1'b0;
        end else if (state == ST_PTR_CAP) begin
            ck      <= '0;
            ck_sent <= 1'b0;
        end else begin
            if (inflight) begin
                ck <= ck ^ i_dram_data;
            end
            if (ck_push) begin
                ck_sent <= 1'b1;
            end
        end
    end
`else
    assign push_valid = inflight;
    assign push_data  = i_dram_data;
    assign push_last  = inflight_last;
    assign issue_last = (rd_addr == END_A);
`endif

    // Control registers: state, start edge history, timeout, read address and in-flight tag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            start_q       <= 1'b1;  // a level still high after reset is not a fresh edge
            to_cnt        <= '0;
            rd_addr       <= '0;
            rd_pending    <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nxt;
            start_q       <= i_start;
            inflight      <= issue;
            inflight_last <= issue & issue_last;
            to_cnt        <= (state == ST_WAIT_BUSY) ? to_cnt + TO_W'(1) : '0;
            if (state == ST_PTR_CAP) begin
                rd_addr    <= base;
                rd_pending <= ~base_past_end;
            end else if (issue) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                if (rd_addr == END_A) begin
                    rd_pending <= 1'b0;
                end
            end
        end
    end

    // Next-state, DRAM port drive and read issue; reads are credit-gated by buffer space.
    always_comb begin
        state_nxt   = state;
        o_dram_rd   = 1'b0;
        o_dram_addr = '0;
        o_active    = 1'b0;
        o_done      = 1'b0;
        issue       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start & ~start_q) state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if ((|i_busy) || (to_cnt == TO_LAST)) state_nxt = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (i_busy == '0) state_nxt = ST_FETCH_PTR;
            end
            ST_FETCH_PTR: begin
                o_active    = 1'b1;
                o_dram_rd   = 1'b1;
                o_dram_addr = PTR_A;
                state_nxt   = ST_PTR_CAP;
            end
            ST_PTR_CAP: begin
                o_active = 1'b1;
`ifdef STREAM_CHECKSUM_EN
                state_nxt = ST_STREAM;
`else
                state_nxt = base_past_end ? ST_DONE : ST_STREAM;
`endif
            end
            ST_STREAM: begin
                o_active    = 1'b1;
                issue       = rd_pending & push_ready &
                              (credit_use(sb_count, pop, inflight) < 3'd2);
                o_dram_rd   = issue;
                o_dram_addr = rd_addr;
                if (pop & o_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    dram_result_streamer_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (i_clk),
        .rst      (i_rst),
        .s_tdata  (push_data),
        .s_tlast  (push_last),
        .s_tvalid (push_valid),
        .s_tready (push_ready),
        .m_tdata  (o_data),
        .m_tlast  (o_last),
        .m_tvalid (o_valid),
        .m_tready (i_ready),
        .count    (sb_count)
    );

endmodule

// File: tb/tb_dram_result_streamer.sv
// tb/tb_dram_result_streamer.sv - scoreboard bench for dram_result_streamer; honours STREAM_CHECKSUM_EN
module tb_dram_result_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [3:0]  busy = 4'b0000;
    logic        dram_rd;
    logic [15:0] dram_addr;
    logic [7:0]  dram_q = 8'h00;
    logic [7:0]  dout;
    logic        dvalid;
    logic        dlast;
    logic        active;
    logic        done;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  mem [0:511];
    logic [8:0]  sb [$];
    int          rx_cnt = 0;
    int          cyc = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    logic        stall_prev = 1'b0;
    logic        last_prev = 1'b0;
    logic [7:0]  held_data = 8'h00;
    logic        held_last = 1'b0;
    bit          rdy_rand = 1'b0;

`ifdef STREAM_CHECKSUM_EN
    localparam int CK_EXTRA = 1;
`else
    localparam int CK_EXTRA = 0;
`endif

    always #5 clk = ~clk;

    dram_result_streamer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_busy      (busy),
        .o_dram_rd   (dram_rd),
        .o_dram_addr (dram_addr),
        .i_dram_data (dram_q),
        .o_data      (dout),
        .o_valid     (dvalid),
        .i_ready     (ready),
        .o_last      (dlast),
        .o_active    (active),
        .o_done      (done)
    );

    // One-cycle-latency DRAM read port and a free-running cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dram_rd) dram_q <= (dram_addr < 16'd512) ? mem[dram_addr[8:0]] : 8'hEE;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random backpressure source, active only while rdy_rand is set.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) ready = ($urandom_range(0, 1) == 1);
    end

    // Output monitor: scoreboard pop, hold-under-stall, o_done timing, DRAM ownership.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            last_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", dvalid, 1'b1);
                chk("hold_data", dout, held_data);
                chk("hold_last", dlast, held_last);
            end
            if (done || last_prev) chk("done_after_last", done, last_prev);
            if (dram_rd) chk("rd_only_when_active", active, 1'b1);
            last_prev = 1'b0;
            if (dvalid && ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_byte", sb.size(), 1);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk("data", dout, e[7:0]);
                    chk("last", dlast, e[8]);
                end
                rx_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc  = cyc;
                last_prev = dlast;
            end
            stall_prev = dvalid && !ready;
            held_data  = dout;
            held_last  = dlast;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input int base);
        logic [7:0] x;
        logic       l;
        x = 8'h00;
        for (int a = base; a <= 511; a++) begin
            l = (a == 511) && (CK_EXTRA == 0);
            sb.push_back({l, mem[a[8:0]]});
            x ^= mem[a[8:0]];
        end
        if (CK_EXTRA == 1) sb.push_back({1'b1, x});
    endtask

    task automatic begin_run(input logic [7:0] ptr);
        mem[12]   = ptr;
        rx_cnt    = 0;
        first_cyc = -1;
        last_cyc  = -1;
        sb.delete();
        push_stream(int'(ptr));
    endtask

    task automatic start_with_busy(input int busy_cycles);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        busy  = 4'b0101;
        tick(busy_cycles);
        busy  = 4'b0000;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        chk("done_seen", done, 1'b1);
    endtask

    task automatic check_end(input string tag, input int nbytes);
        chk({tag, "_sb_drained"}, sb.size(), 0);
        chk({tag, "_byte_count"}, rx_cnt, nbytes);
    endtask

    task automatic check_idle_outputs();
        chk("rst_valid", dvalid, 1'b0);
        chk("rst_data", dout, 8'h00);
        chk("rst_last", dlast, 1'b0);
        chk("rst_active", active, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dram_rd", dram_rd, 1'b0);
        chk("rst_dram_addr", dram_addr, 16'h0000);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 13 + 7);

        // reset state
        tick(3);
        @(negedge clk);
        check_idle_outputs();
        tick(1);
        rst = 1'b0;
        tick(2);

        // case 1: busy pulse 100 cycles, ready held high, pointer 0x00
        begin_run(8'h00);
        ready = 1'b1;
        start = 1'b1;
        tick(2);
        start = 1'b0;
        busy  = 4'b1011;
        tick(100);
        @(negedge clk);
        chk("no_fetch_while_busy", active, 1'b0);
        tick(1);
        busy = 4'b0000;
        wait_done(2000);
        check_end("c1", 512 + CK_EXTRA);
        chk("c1_throughput", last_cyc - first_cyc + 1, 512 + CK_EXTRA);
        tick(3);

        // case 2: pointer 0xF0, random backpressure
        begin_run(8'hF0);
        rdy_rand = 1'b1;
        start_with_busy(10);
        wait_done(3000);
        check_end("c2", 272 + CK_EXTRA);
        rdy_rand = 1'b0;
        tick(1);
        ready = 1'b1;
        tick(3);

        // case 3: busy never asserts, timeout after 64 cycles in WAIT_BUSY
        begin_run(8'h00);
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!active && n < 200);
        chk("busy_timeout_latency", n, 67);
        tick(1);
        start = 1'b0;
        wait_done(2000);
        check_end("c3", 512 + CK_EXTRA);
        chk("c3_throughput", last_cyc - first_cyc + 1, 512 + CK_EXTRA);
        tick(3);

        // case 4: reset mid-stream, then full replay from base
        begin_run(8'h80);
        start_with_busy(5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rx_cnt < 37 && n < 2000);
        chk("c4_reached_byte37", rx_cnt >= 37, 1'b1);
        tick(1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs();
        tick(1);
        rst = 1'b0;
        tick(2);
        begin_run(8'h80);
        start_with_busy(5);
        wait_done(2000);
        check_end("c4", 384 + CK_EXTRA);
        tick(3);

        // case 5: start toggled during STREAM is ignored
        begin_run(8'h40);
        start_with_busy(5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dvalid && n < 500);
        chk("c5_stream_started", dvalid, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            start = 1'b1;
            tick(2);
            start = 1'b0;
        end
        wait_done(2000);
        check_end("c5", 448 + CK_EXTRA);
        tick(80);
        @(negedge clk);
        chk("c5_no_restart", active, 1'b0);
        chk("c5_count_unchanged", rx_cnt, 448 + CK_EXTRA);
        tick(1);

        // case 6: pointer 0xFE under backpressure (checksum byte last when enabled)
        begin_run(8'hFE);
        rdy_rand = 1'b1;
        start_with_busy(5);
        wait_done(2000);
        check_end("c6", 258 + CK_EXTRA);
        rdy_rand = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
